// File: rtl/nn_fp16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_fp16_pkg                                                          |
// | FP16 constants and field positions shared by the activation units.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nn_fp16_pkg;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_TWO  = 16'h4000;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int MAN_MSB  = 9;
  localparam int MAN_LSB  = 0;

  localparam logic [4:0] EXP_INF = 5'h1F;

  typedef struct packed {
    logic [15:0] y;
    logic        dprime;
    logic        sat;
  } act_t;

endpackage
`default_nettype wire

// File: rtl/fp16_hard_act_classify.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp16_hard_act_classify                                               |
// | Combinational loose hard-sigmoid: value, derivative flag, sat flag. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fp16_hard_act_classify
  import nn_fp16_pkg::*;
(
  input  logic [15:0] x_i,
  output logic [15:0] y_o,
  output logic        dprime_o,
  output logic        sat_o
);

  logic [4:0] w_exp;
  logic [9:0] w_man;
  logic       w_nan;

  assign w_exp = x_i[EXP_MSB:EXP_LSB];
  assign w_man = x_i[MAN_MSB:MAN_LSB];
  assign w_nan = (w_exp == EXP_INF) && (w_man != 10'd0);

  // Exponent MSB set means |x| >= 2.0 (Inf included); NaN takes priority.
  always_comb begin
    y_o      = x_i;
    dprime_o = 1'b1;
    sat_o    = 1'b0;
    if (w_nan) begin
      y_o      = FP16_QNAN;
      dprime_o = 1'b0;
    end else if (x_i[EXP_MSB]) begin
      y_o      = {x_i[SIGN_BIT], FP16_TWO[14:0]};
      dprime_o = 1'b0;
      sat_o    = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sigmoid_fwd_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sigmoid_fwd_stream                                                   |
// | Two-stage hard-sigmoid stream with vector framing and sat counting. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sigmoid_fwd_stream
  import nn_fp16_pkg::*;
#(
  parameter int VEC_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [15:0] OUT_DATA,
  output logic        OUT_DPRIME,
  output logic        OUT_LAST,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [7:0]  SAT_COUNT,
  output logic        SAT_VALID
);

  localparam int              IDX_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic [7:0]      SAT_MAX  = 8'hFF;

  logic [15:0]      w_y;
  logic             w_dp;
  logic             w_sat;
  act_t             w_act;

  act_t             s1_q, s2_q;
  logic             s1_valid_q, s2_valid_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       sat_count_q, sat_count_d;
  logic             sat_valid_q, sat_valid_d;

  logic             w_s2_ready;
  logic             w_in_ready;
  logic             w_out_xfer;
  logic             w_is_last;
  logic [7:0]       w_acc_inc;

  fp16_hard_act_classify u_classify (
    .x_i      (IN_DATA),
    .y_o      (w_y),
    .dprime_o (w_dp),
    .sat_o    (w_sat)
  );

  assign w_act = {w_y, w_dp, w_sat};

  assign w_s2_ready = !s2_valid_q || OUT_READY;
  assign w_in_ready = !s1_valid_q || w_s2_ready;
  assign w_out_xfer = s2_valid_q && OUT_READY;
  assign w_is_last  = (idx_q == LAST_IDX);
  assign w_acc_inc  = (acc_q == SAT_MAX) ? SAT_MAX : acc_q + {7'd0, s2_q.sat};

  // The closing beat folds its own increment into the published count.
  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    sat_count_d = sat_count_q;
    sat_valid_d = 1'b0;
    if (w_out_xfer) begin
      if (w_is_last) begin
        idx_d       = '0;
        acc_d       = 8'd0;
        sat_count_d = w_acc_inc;
        sat_valid_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        acc_d = w_acc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      idx_q       <= '0;
      acc_q       <= 8'd0;
      sat_count_q <= 8'd0;
      sat_valid_q <= 1'b0;
    end else begin
      if (w_in_ready) begin
        s1_valid_q <= IN_VALID;
        if (IN_VALID) s1_q <= w_act;
      end
      if (w_s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_q <= s1_q;
      end
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      sat_count_q <= sat_count_d;
      sat_valid_q <= sat_valid_d;
    end
  end

  assign IN_READY   = w_in_ready;
  assign OUT_DATA   = s2_q.y;
  assign OUT_DPRIME = s2_q.dprime;
  assign OUT_VALID  = s2_valid_q;
  assign OUT_LAST   = s2_valid_q && w_is_last;
  assign SAT_COUNT  = sat_count_q;
  assign SAT_VALID  = sat_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_fwd_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sigmoid_fwd_stream                                                |
// | Self-checking bench: reference queue model plus literal sequences.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sigmoid_fwd_stream;

  localparam int VL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] OUT_DATA;
  logic        OUT_DPRIME;
  logic        OUT_LAST;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  SAT_COUNT;
  logic        SAT_VALID;

  logic [15:0] b_IN_DATA;
  logic        b_IN_VALID;
  logic        b_IN_READY;
  logic [15:0] b_OUT_DATA;
  logic        b_OUT_DPRIME;
  logic        b_OUT_LAST;
  logic        b_OUT_VALID;
  logic        b_OUT_READY;
  logic [7:0]  b_SAT_COUNT;
  logic        b_SAT_VALID;

  always #5 clk = ~clk;

  sigmoid_fwd_stream #(.VEC_LEN(VL)) dut (
    .clk(clk), .rst(rst),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_DPRIME(OUT_DPRIME), .OUT_LAST(OUT_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SAT_COUNT(SAT_COUNT), .SAT_VALID(SAT_VALID)
  );

  sigmoid_fwd_stream #(.VEC_LEN(256)) dut256 (
    .clk(clk), .rst(rst),
    .IN_DATA(b_IN_DATA), .IN_VALID(b_IN_VALID), .IN_READY(b_IN_READY),
    .OUT_DATA(b_OUT_DATA), .OUT_DPRIME(b_OUT_DPRIME), .OUT_LAST(b_OUT_LAST),
    .OUT_VALID(b_OUT_VALID), .OUT_READY(b_OUT_READY),
    .SAT_COUNT(b_SAT_COUNT), .SAT_VALID(b_SAT_VALID)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the classification rules.
  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction
  function automatic logic [15:0] ref_y(input logic [15:0] x);
    if (is_nan(x)) return 16'h7E00;
    if (x[14])     return x[15] ? 16'hC000 : 16'h4000;
    return x;
  endfunction
  function automatic logic ref_dp(input logic [15:0] x);
    return !is_nan(x) && !x[14];
  endfunction
  function automatic logic ref_sat(input logic [15:0] x);
    return !is_nan(x) && x[14];
  endfunction

  logic [15:0] pipe_q[$];
  logic [16:0] obs_q[$];
  int          last_pos_q[$];
  int          satv_q[$];
  int          beat, total_beats, acc, exp_cnt;
  logic        exp_sv, prev_stall, prev_dp, prev_last;
  logic [15:0] prev_data;
  int          rdy_mode = 0;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      OUT_READY = 1'b1;
    else if (rdy_mode == 1) OUT_READY = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic [15:0] x;
    if (!rst) begin
      pipe_q.delete(); obs_q.delete(); last_pos_q.delete(); satv_q.delete();
      beat = 0; total_beats = 0; acc = 0; exp_cnt = 0;
      exp_sv = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("in_ready", IN_READY, (pipe_q.size() < 2) || OUT_READY);
      chk("sat_valid", SAT_VALID, exp_sv);
      chk("sat_count", SAT_COUNT, exp_cnt);
      if (prev_stall) begin
        chk("hold_valid", OUT_VALID, 1);
        chk("hold_data", OUT_DATA, prev_data);
        chk("hold_dprime", OUT_DPRIME, prev_dp);
        chk("hold_last", OUT_LAST, prev_last);
      end
      if (!OUT_VALID) chk("last_idle", OUT_LAST, 0);
      exp_sv = 1'b0;
      if (OUT_VALID && OUT_READY) begin
        if (pipe_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL spurious_beat: got %0h expected no beat", OUT_DATA);
        end else begin
          x = pipe_q.pop_front();
          chk("out_data", OUT_DATA, ref_y(x));
          chk("out_dprime", OUT_DPRIME, ref_dp(x));
          chk("out_last", OUT_LAST, beat == VL - 1);
          obs_q.push_back({OUT_DATA, OUT_DPRIME});
          if (beat == VL - 1) last_pos_q.push_back(total_beats);
          total_beats++;
          if (ref_sat(x)) acc = (acc < 255) ? acc + 1 : 255;
          if (beat == VL - 1) begin
            exp_cnt = acc; acc = 0; exp_sv = 1'b1;
            satv_q.push_back(exp_cnt);
          end
          beat = (beat + 1) % VL;
        end
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
      prev_dp    = OUT_DPRIME;
      prev_last  = OUT_LAST;
      if (IN_VALID && IN_READY) pipe_q.push_back(IN_DATA);
    end
  end

  task automatic send(input logic [15:0] x);
    logic a;
    int   n = 0;
    IN_VALID = 1'b1;
    IN_DATA  = x;
    do begin
      @(negedge clk); a = IN_READY;
      @(posedge clk); #1; n++;
    end while (!a && n < 100);
    if (!a) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", x);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0; OUT_READY = 1'b1; IN_VALID = 1'b0;
    while ((pipe_q.size() != 0 || OUT_VALID) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_done", pipe_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_out_dprime", OUT_DPRIME, 0);
    chk("rst_out_last", OUT_LAST, 0);
    chk("rst_sat_count", SAT_COUNT, 0);
    chk("rst_sat_valid", SAT_VALID, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_in_ready", IN_READY, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] sweep_in  [7];
    logic [16:0] sweep_exp [7];
    int nacc, k, beats2;
    logic found;

    sweep_in  = '{16'h3C00, 16'hBC00, 16'h4000, 16'hC500, 16'h7C00, 16'h0001, 16'h7C01};
    sweep_exp = '{{16'h3C00, 1'b1}, {16'hBC00, 1'b1}, {16'h4000, 1'b0}, {16'hC000, 1'b0},
                  {16'h4000, 1'b0}, {16'h0001, 1'b1}, {16'h7E00, 1'b0}};

    rst = 1'b1; IN_VALID = 1'b0; IN_DATA = 16'h0; OUT_READY = 1'b1;
    b_IN_VALID = 1'b0; b_IN_DATA = 16'h0; b_OUT_READY = 1'b1;

    #3 rst = 1'b0;
    #1;
    chk("init_out_valid", OUT_VALID, 0);
    chk("init_out_data", OUT_DATA, 0);
    chk("init_sat_count", SAT_COUNT, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("init_in_ready", IN_READY, 1);

    chk("model_neg5", ref_y(16'hC500), 16'hC000);
    chk("model_nan", ref_y(16'h7C01), 16'h7E00);
    chk("model_inf_dp", ref_dp(16'h7C00), 0);
    chk("model_nan_sat", ref_sat(16'h7C01), 0);
    chk("model_sub", ref_y(16'h0001), 16'h0001);

    // Sweep with latency pinned on the first two elements.
    send(sweep_in[0]);
    chk("lat_valid_early", OUT_VALID, 0);
    send(sweep_in[1]);
    chk("lat_valid", OUT_VALID, 1);
    chk("lat_data", OUT_DATA, 16'h3C00);
    for (int i = 2; i < 7; i++) send(sweep_in[i]);
    drain();
    chk("sweep_count", obs_q.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("sweep_%0d", i), obs_q[i], sweep_exp[i]);

    // Framing: vector 0 has five saturating inputs, vector 1 none (one NaN).
    do_reset();
    for (int i = 0; i < 2 * VL; i++) begin
      if (i < VL) send((i % 3 == 2) ? 16'h4400 : 16'h3800);
      else if (i == VL + 4) send(16'h7C01);
      else send(16'($urandom_range(0, 16'h3FFF)));
    end
    drain();
    chk("frame_lasts", last_pos_q.size(), 2);
    chk("frame_last0", last_pos_q[0], 15);
    chk("frame_last1", last_pos_q[1], 31);
    chk("frame_pulses", satv_q.size(), 2);
    chk("frame_sat0", satv_q[0], 5);
    chk("frame_sat1", satv_q[1], 0);

    // Backpressure from an empty pipeline.
    do_reset();
    for (int i = 0; i < 3; i++) send(16'h1000 + 16'(i));
    repeat (3) begin @(posedge clk); #1; end
    rdy_mode = 2; OUT_READY = 1'b0;
    nacc = 0; k = 0;
    IN_VALID = 1'b1; IN_DATA = 16'h2000;
    repeat (5) begin
      logic a;
      @(negedge clk); a = IN_READY;
      @(posedge clk); #1;
      if (a) begin nacc++; k++; IN_DATA = 16'h2000 + 16'(k); end
    end
    chk("bp_accepts", nacc, 2);
    chk("bp_in_ready_low", IN_READY, 0);
    OUT_READY = 1'b1; rdy_mode = 0;
    for (int i = 0; i < 6; i++) send(16'h2000 + 16'(k + i));
    drain();

    // Random traffic under random backpressure.
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(16'($urandom));
    end
    drain();

    // Reset in the middle of a vector.
    do_reset();
    for (int i = 0; i < 7; i++) send(16'h4400);
    do_reset();
    for (int i = 0; i < VL; i++) send((i < 3) ? 16'h4400 : 16'h3000);
    drain();
    chk("mid_lasts", last_pos_q.size(), 1);
    chk("mid_last_pos", last_pos_q[0], 15);
    chk("mid_sat", satv_q[0], 3);

    // 256-element vectors of saturating inputs clamp the count.
    b_IN_DATA = 16'h4400; b_IN_VALID = 1'b1;
    beats2 = 0; found = 1'b0;
    for (int c = 0; c < 800 && !found; c++) begin
      @(negedge clk);
      if (b_SAT_VALID) found = 1'b1;
      else if (b_OUT_VALID) beats2++;
    end
    chk("sat256_pulse", found, 1);
    chk("sat256_count", b_SAT_COUNT, 8'd255);
    chk("sat256_beats", beats2, 256);
    b_IN_VALID = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
